// File: rtl/branch_unit.sv
`default_nettype none
// ============================================================================
// Module      : branch_unit
// Description : ID-stage branch resolver and branch-hazard stall controller
//               for a 5-stage MIPS pipeline. Resolves BEQ/BNE from the
//               comparator equality flag, drives PC-select, branch target and
//               IF/ID flush, and stalls the front end while a branch operand
//               is still in flight.
//               Optional feature macro: BRANCH_STATS_EN (statistics counters).
// Revision    : 1.0 - initial release
// ============================================================================
module branch_unit #(
    parameter int INST_SZ     = 32,
    parameter int REG_ADDR_SZ = 5,
    parameter int STAT_SZ     = 16
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_branch,
    input  logic                   i_bne,
    input  logic                   i_comparison,
    input  logic [REG_ADDR_SZ-1:0] i_rs,
    input  logic [REG_ADDR_SZ-1:0] i_rt,
    input  logic [INST_SZ-1:0]     i_pc_plus4,
    input  logic [INST_SZ-1:0]     i_imm_ext,
    input  logic                   i_ex_reg_write,
    input  logic                   i_ex_mem_read,
    input  logic [REG_ADDR_SZ-1:0] i_ex_rd,
    input  logic                   i_mem_mem_read,
    input  logic [REG_ADDR_SZ-1:0] i_mem_rd,
    output logic                   o_stall,
    output logic                   o_pc_src,
    output logic [INST_SZ-1:0]     o_branch_target,
    output logic                   o_flush_if_id,
    output logic [STAT_SZ-1:0]     o_taken_count,
    output logic [STAT_SZ-1:0]     o_stall_count
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_STALL   = 2'd1,
        ST_RESOLVE = 2'd2
    } state_t;

    state_t r_state;

    logic w_ex_hit;
    logic w_mem_hit;
    logic w_need_two;
    logic w_need_one;
    logic w_stall;
    logic w_resolve;
    logic w_taken;

    // Register $zero is never a real producer, so it never creates a hazard.
    assign w_ex_hit  = i_ex_reg_write && (i_ex_rd != '0) &&
                       ((i_ex_rd == i_rs) || (i_ex_rd == i_rt));
    assign w_mem_hit = i_mem_mem_read && (i_mem_rd != '0) &&
                       ((i_mem_rd == i_rs) || (i_mem_rd == i_rt));

    // A load in EX needs two bubbles; any other in-flight producer needs one.
    assign w_need_two = w_ex_hit && i_ex_mem_read;
    assign w_need_one = !w_need_two && (w_ex_hit || w_mem_hit);

    // State sequencing: stall length is fixed when the hazard is detected.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_branch && w_need_two)
                        r_state <= ST_STALL;
                    else if (i_branch && w_need_one)
                        r_state <= ST_RESOLVE;
                    else
                        r_state <= ST_IDLE;
                end
                ST_STALL: begin
                    // A squashed branch abandons the sequence.
                    r_state <= i_branch ? ST_RESOLVE : ST_IDLE;
                end
                ST_RESOLVE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Stall / resolve decode from current state and ID inputs.
    always_comb begin
        w_stall   = 1'b0;
        w_resolve = 1'b0;
        if (!i_reset) begin
            case (r_state)
                ST_IDLE: begin
                    if (i_branch) begin
                        if (w_need_two || w_need_one)
                            w_stall = 1'b1;
                        else
                            w_resolve = 1'b1;
                    end
                end
                ST_STALL: begin
                    w_stall = i_branch;
                end
                ST_RESOLVE: begin
                    w_resolve = i_branch;
                end
                default: begin
                    w_stall   = 1'b0;
                    w_resolve = 1'b0;
                end
            endcase
        end
    end

    assign w_taken = w_resolve && (i_comparison ^ i_bne);

    assign o_stall         = w_stall;
    assign o_pc_src        = w_taken;
    assign o_flush_if_id   = w_taken;
    // Target wraps modulo 2^INST_SZ; forced to zero while in reset.
    assign o_branch_target = i_reset ? '0 : (i_pc_plus4 + (i_imm_ext << 2));

`ifdef BRANCH_STATS_EN
    localparam logic [STAT_SZ-1:0] c_stat_max = '1;

    logic [STAT_SZ-1:0] r_taken_count;
    logic [STAT_SZ-1:0] r_stall_count;

    // Saturating event counters for taken branches and stall cycles.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_taken_count <= '0;
            r_stall_count <= '0;
        end else begin
            if (w_taken && (r_taken_count != c_stat_max))
                r_taken_count <= r_taken_count + 1'b1;
            if (w_stall && (r_stall_count != c_stat_max))
                r_stall_count <= r_stall_count + 1'b1;
        end
    end

    assign o_taken_count = i_reset ? '0 : r_taken_count;
    assign o_stall_count = i_reset ? '0 : r_stall_count;
`else
    assign o_taken_count = '0;
    assign o_stall_count = '0;
`endif

endmodule
`default_nettype wire
